// File: rtl/microwave_time_entry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | microwave_time_entry_pkg: shared state encoding, BCD constants |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package microwave_time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUNNING = 3'd3,
    ST_PAUSED  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned DIGIT_W            = 4;
  localparam logic [3:0]  MAX_DIGIT          = 4'd9;
  localparam logic [3:0]  MAX_SEC_TENS       = 4'd5;
  localparam int          DEFAULT_QUICK_SECS = 30;

  // Packs a seconds count into the MM:SS BCD layout {min_t, min_o, sec_t, sec_o}.
  function automatic logic [15:0] secs_to_bcd(input int secs);
    int m;
    int s;
    m = (secs / 60) % 100;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/entry_digit_shift.sv
`default_nettype none
// +----------------------------------------------------------------+
// | entry_digit_shift: BCD keypad shift register with digit count  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module entry_digit_shift
  import microwave_time_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          shift_i,
  input  logic [DIGIT_W-1:0]            code_i,
  input  logic                          clr_i,
  input  logic                          preset_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] preset_val_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          all_zero_o,
  output logic                          sec_tens_ok_o
);

  localparam int W = NUM_DIGITS * DIGIT_W;

  logic [W-1:0]     digits_q;
  logic [W-1:0]     digits_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear beats preset beats shift; a full register drops its oldest digit.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clr_i) begin
      digits_d = '0;
      count_d  = '0;
    end else if (preset_i) begin
      digits_d = preset_val_i;
      count_d  = CNT_W'(NUM_DIGITS);
    end else if (shift_i) begin
      digits_d = {digits_q[W-DIGIT_W-1:0], code_i};
      if (count_q != CNT_W'(NUM_DIGITS)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign digits_o      = digits_q;
  assign count_o       = count_q;
  assign all_zero_o    = (digits_q == '0);
  assign sec_tens_ok_o = (digits_q[2*DIGIT_W-1 -: DIGIT_W] <= MAX_SEC_TENS);

endmodule
`default_nettype wire

// File: rtl/microwave_time_entry.sv
`default_nettype none
// +----------------------------------------------------------------+
// | microwave_time_entry: keypad cook-time entry and cook control  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module microwave_time_entry
  import microwave_time_entry_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int QUICK_SECS  = DEFAULT_QUICK_SECS,
  parameter int DONE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic       door_closed,
  input  logic       all_zero,
  output logic       load,
  output logic [3:0] data_min_t,
  output logic [3:0] data_min_o,
  output logic [3:0] data_sec_t,
  output logic [3:0] data_sec_o,
  output logic       count_en,
  output logic       clear_out,
  output logic       done,
  output logic       entry_err,
  output logic [2:0] state_dbg
);

  localparam int                          CNT_W     = $clog2(NUM_DIGITS + 1);
  localparam int                          TMR_W     = $clog2(DONE_CYCLES + 1);
  localparam logic [NUM_DIGITS*DIGIT_W-1:0] QUICK_BCD = secs_to_bcd(QUICK_SECS);

  state_t                        state_q;
  logic                          load_q;
  logic                          run_q;
  logic                          done_q;
  logic                          err_q;
  logic                          clr_out_q;
  logic [TMR_W-1:0]              tmr_q;

  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [CNT_W-1:0]              digit_cnt;
  logic                          digits_zero;
  logic                          sec_tens_ok;
  logic                          is_digit;
  logic                          entry_ok;
  logic                          shift_en;
  logic                          clr_digits;
  logic                          preset_quick;

  assign is_digit = key_valid && (key_code <= MAX_DIGIT);
  assign entry_ok = door_closed && !digits_zero && sec_tens_ok && (digit_cnt != '0);

  // Digit-register controls follow the same stop > start > key priority as the FSM.
  always_comb begin
    shift_en     = 1'b0;
    clr_digits   = 1'b0;
    preset_quick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_key) begin
          if (start_key) preset_quick = door_closed;
          else           shift_en     = is_digit;
        end
      end
      ST_ENTRY: begin
        if (stop_key)        clr_digits = 1'b1;
        else if (!start_key) shift_en   = is_digit;
      end
      ST_PAUSED: clr_digits = stop_key;
      ST_DONE:   clr_digits = stop_key || (tmr_q == '0);
      default: ;
    endcase
  end

  entry_digit_shift #(
    .NUM_DIGITS (NUM_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digits (
    .clk_i         (clk),
    .rst_ni        (clear),
    .shift_i       (shift_en),
    .code_i        (key_code),
    .clr_i         (clr_digits),
    .preset_i      (preset_quick),
    .preset_val_i  (QUICK_BCD),
    .digits_o      (digits),
    .count_o       (digit_cnt),
    .all_zero_o    (digits_zero),
    .sec_tens_ok_o (sec_tens_ok)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      load_q    <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_out_q <= 1'b1;
      tmr_q     <= '0;
    end else begin
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_out_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!stop_key && start_key) begin
            if (door_closed) begin
              state_q <= ST_LOAD;
              load_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (!stop_key && is_digit) begin
            state_q <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (stop_key) begin
            state_q <= ST_IDLE;
          end else if (start_key) begin
            if (entry_ok) begin
              state_q <= ST_LOAD;
              load_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state_q <= ST_RUNNING;
          run_q   <= 1'b1;
        end
        ST_RUNNING: begin
          // Door and stop both pause; terminal count is only honoured while running.
          if (stop_key || !door_closed) begin
            state_q <= ST_PAUSED;
            run_q   <= 1'b0;
          end else if (all_zero) begin
            state_q <= ST_DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
            tmr_q   <= TMR_W'(DONE_CYCLES - 1);
          end
        end
        ST_PAUSED: begin
          if (stop_key) begin
            state_q   <= ST_IDLE;
            clr_out_q <= 1'b0;
          end else if (start_key) begin
            if (door_closed) begin
              state_q <= ST_RUNNING;
              run_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (stop_key || (tmr_q == '0)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Enable drops in the same cycle the door opens or the chain reaches zero.
  assign count_en   = run_q && door_closed && !all_zero;
  assign load       = load_q;
  assign done       = done_q;
  assign entry_err  = err_q;
  assign clear_out  = clr_out_q;
  assign state_dbg  = state_q;
  assign data_sec_o = digits[0*DIGIT_W +: DIGIT_W];
  assign data_sec_t = digits[1*DIGIT_W +: DIGIT_W];
  assign data_min_o = digits[2*DIGIT_W +: DIGIT_W];
  assign data_min_t = digits[3*DIGIT_W +: DIGIT_W];

endmodule
`default_nettype wire
